// File: rtl/alu_mul_seq.sv
// Sequential 32x32 -> 32 shift-and-add multiplier that borrows the
// execute-stage ALU adder through its a/b/aluop/out connection.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;
endpackage

module alu_mul_seq
  import cpu_types_pkg::*;
(
  input  logic   CLK,
  input  logic   nRST,
  input  logic   start,
  input  word_t  op_a,
  input  word_t  op_b,
  output logic   busy,
  output logic   done,
  output word_t  product,
  output word_t  alu_a,
  output word_t  alu_b,
  output aluop_t alu_op,
  input  word_t  alu_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t     state_q, state_d;
  word_t      acc_q, acc_d;
  word_t      mcand_q, mcand_d;
  word_t      mplier_q, mplier_d;
  word_t      product_q, product_d;
  logic [4:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = ALU_ADD;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        alu_a = acc_q;
        alu_b = mcand_q;
        if (mplier_q[0]) begin
          acc_d = alu_out;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        // Always 32 iterations; no early exit when mplier drains.
        if (cnt_q == 5'd31) begin
          state_d   = DONE;
          product_d = acc_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq; a behavioural adder stands in
// for the execute-stage ALU.
module tb_alu_mul_seq;
  import cpu_types_pkg::*;

  logic   CLK;
  logic   nRST;
  logic   start;
  word_t  op_a;
  word_t  op_b;
  logic   busy;
  logic   done;
  word_t  product;
  word_t  alu_a;
  word_t  alu_b;
  aluop_t alu_op;
  word_t  alu_out;

  int n_tests;
  int n_fail;

  alu_mul_seq dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out)
  );

  assign alu_out = (alu_op == ALU_ADD) ? alu_a + alu_b : 32'hBAD0_BAD0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle whose closing edge samples start.
  task automatic do_mul(input string tag,
                        input word_t a,
                        input word_t b,
                        input word_t exp);
    int c;
    @(negedge CLK);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    op_a  = 32'h5555_AAAA;
    op_b  = 32'hAAAA_5555;
    c = 1;
    chk({tag, " busy@1"}, 32'(busy), 32'd1);
    while (!done && c < 45) begin
      @(negedge CLK);
      c++;
    end
    chk({tag, " latency"}, c, 33);
    chk({tag, " product"}, product, exp);
    chk({tag, " busy@33"}, 32'(busy), 32'd1);
    @(negedge CLK);
    chk({tag, " done@34"}, 32'(done), 32'd0);
    chk({tag, " busy@34"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int    done_cnt;
    int    d_cyc [2];
    word_t d_prod [2];
    int    bad;

    n_tests = 0;
    n_fail  = 0;
    nRST  = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge CLK);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst product", product, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst alu_op", 32'(alu_op), 32'(ALU_ADD));
    nRST = 1'b1;

    do_mul("3x5", 32'd3, 32'd5, 32'h0000_000F);
    do_mul("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    do_mul("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6);
    do_mul("ovf", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    do_mul("zero", 32'd0, 32'hDEAD_BEEF, 32'h0000_0000);

    // start held high across two complete operations
    done_cnt = 0;
    d_cyc[0] = -1;
    d_cyc[1] = -1;
    d_prod[0] = '0;
    d_prod[1] = '0;
    @(negedge CLK);
    for (int c = 0; c < 76; c++) begin
      if (c > 0) @(negedge CLK);
      if (done) begin
        if (done_cnt < 2) begin
          d_cyc[done_cnt]  = c;
          d_prod[done_cnt] = product;
        end
        done_cnt++;
      end
      start = (c < 40);
      op_a  = (c >= 5) ? 32'd7 : 32'd2;
      op_b  = 32'd9;
    end
    start = 1'b0;
    chk("held done count", done_cnt, 2);
    chk("held done1 cycle", d_cyc[0], 33);
    chk("held product1", d_prod[0], 32'h12);
    chk("held done2 cycle", d_cyc[1], 67);
    chk("held product2", d_prod[1], 32'h3F);

    // asynchronous reset in the middle of a run
    do_mul("pre 4x4", 32'd4, 32'd4, 32'h10);
    @(negedge CLK);
    op_a  = 32'd100;
    op_b  = 32'd100;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (9) @(negedge CLK);
    chk("mid busy before rst", 32'(busy), 32'd1);
    nRST = 1'b0;
    #2;
    chk("mid rst product", product, 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst alu_a", alu_a, 32'd0);
    chk("mid rst alu_b", alu_b, 32'd0);
    nRST = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge CLK);
      if (done) done_cnt++;
    end
    chk("mid rst no done", done_cnt, 0);
    do_mul("post 4x4", 32'd4, 32'd4, 32'h10);

    // ALU drive: iteration k presents mcand = 1<<k, acc stays 0
    @(negedge CLK);
    op_a  = 32'd1;
    op_b  = 32'h8000_0000;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge CLK);
      if (alu_b !== (32'd1 << k)) bad++;
      if (alu_a !== 32'd0) bad++;
      if (alu_op !== ALU_ADD) bad++;
      if (!busy || done) bad++;
    end
    chk("drive errors", bad, 0);
    @(negedge CLK);
    chk("drive done", 32'(done), 32'd1);
    chk("drive product", product, 32'h8000_0000);
    chk("drive alu_a idle", alu_a, 32'd0);
    chk("drive alu_b idle", alu_b, 32'd0);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative 32-bit shift-and-add multiplier that acts as the requester side of `alu_if`. It drives the ALU's `a`, `b` and `aluop` inputs and consumes `out`, the same connection the `tb` modport exposes. It reuses the datapath adder instead of instantiating a multiplier. It sits beside the ALU in the execute stage and returns the low word of the product after a fixed latency.

## Interface
- No parameters. Widths come from `cpu_types_pkg`: `word_t` is 32 bits and `aluop_t` is the ALU opcode type.
- `CLK  in  1`  system clock; all state changes on the rising edge.
- `nRST  in  1`  asynchronous, active-low reset.
- `start  in  1`  request; sampled only in IDLE.
- `op_a  in  word_t`  multiplicand, captured when start is accepted.
- `op_b  in  word_t`  multiplier, captured when start is accepted.
- `busy  out  1`  high in RUN and DONE.
- `done  out  1`  one-cycle pulse in DONE.
- `product  out  word_t`  registered result, low 32 bits of op_a*op_b.
- `alu_a  out  word_t`  to ALU `a`.
- `alu_b  out  word_t`  to ALU `b`.
- `alu_op  out  aluop_t`  to ALU `aluop`.
- `alu_out  in  word_t`  from ALU `out`. ALU flags N, V and Z are not used.

## Operation
- Internal registers:
  - `acc` (word): accumulator.
  - `mcand` (word): shifts left.
  - `mplier` (word): shifts right.
  - `cnt` (5 bits).
  - `state` ∈ {IDLE, RUN, DONE}.
- IDLE:
  - If start=1, load acc←0, mcand←op_a, mplier←op_b, cnt←0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, every cycle:
  - alu_a=acc, alu_b=mcand, alu_op=ALU_ADD (combinational from the registers).
  - At the edge, if mplier[0]=1 then acc←alu_out, else acc is unchanged.
  - Then mcand←mcand<<1, mplier←mplier>>1 (logical), cnt←cnt+1.
  - When cnt=31 at the edge, go to DONE and load product←(the acc value written that edge).
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Outside RUN: alu_a=0, alu_b=0, alu_op=ALU_ADD.
- Arithmetic:
  - All arithmetic is modulo 2^32; carry-out and the ALU V flag are ignored.
  - The result is identical for signed and unsigned interpretation of the low word.
- Fixed latency: no early termination, even when mplier reaches 0.
- start while busy=1 (RUN or DONE) is ignored. op_a and op_b are not re-sampled.
- product holds its value from DONE until the next DONE. Accepting a new start does not clear it.
- Reset, asynchronous, at any time including mid-RUN:
  - state=IDLE, busy=0, done=0, product=0.
  - acc, mcand, mplier and cnt cleared.
  - alu_a=0, alu_b=0, alu_op=ALU_ADD.
  - An in-flight operation is discarded with no done pulse.

## Timing
- Cycle 0: start=1 sampled in IDLE at the edge ending cycle 0.
- Cycles 1–32: RUN, 32 iterations. busy=1 from cycle 1.
- Cycle 33: DONE. done=1, product valid, busy=1.
- Cycle 34: IDLE, busy=0. The earliest next start is sampled at the end of cycle 34.
- Start-to-done latency is 33 cycles; throughput is one product per 34 cycles.
- The ALU path is combinational within one cycle: alu_a/alu_b → ALU → alu_out → acc must meet the single-cycle constraint.
- done and busy are registered-state decodes with no combinational path from start.

## Test plan
- Basic: op_a=3, op_b=5, start pulse at cycle 0 → done=1 exactly at cycle 33, product=0x0000000F; busy=0 at cycle 34.
- Wrap and sign: op_a=op_b=0xFFFFFFFF → product=0x00000001. op_a=0xFFFFFFF9 (−7), op_b=6 → product=0xFFFFFFD6.
- Overflow discard: op_a=op_b=0x00010000 → product=0x00000000. op_a=0, op_b=0xDEADBEEF → product=0 with the full 33-cycle latency.
- Start while busy: start held high for 40 cycles with op_a=2, op_b=9, changing op_a to 7 at cycle 5 → one done at cycle 33 with product=0x12. A second accept at cycle 34 gives done at cycle 67 with product=0x3F.
- Reset mid-run:
  - Complete 4*4 first, so product=0x10.
  - Start 100*100, then pulse nRST low at cycle 10 of that run → product=0, busy=0, done never pulses, alu_a=alu_b=0.
  - A subsequent start of 4*4 yields done 33 cycles later with product=0x10.
- ALU drive check:
  - During RUN with op_a=1, op_b=0x80000000: alu_b equals 1<<k in iteration k and alu_op=ALU_ADD throughout; acc changes only in iteration 31.
  - Final product=0x80000000.
